// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the wide add/subtract sequencer.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_W = 32;

    // Word-index width; a single-bit index is kept as the floor.
    function automatic int idx_w(input int words);
        return (words > 32'sd1) ? $clog2(words) : 32'sd1;
    endfunction

endpackage

// File: rtl/carry_skip_32bit.sv
// 32-bit carry-skip adder: eight 4-bit ripple blocks, each bypassed when all bits propagate.
module carry_skip_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] p_s;
    logic [31:0] g_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Ripple within each block; the block carry skips the ripple when the block fully propagates.
    always_comb begin
        logic c_v;
        logic bc_v;
        sum  = 32'd0;
        cout = 1'b0;
        c_v  = 1'b0;
        bc_v = cin;
        for (int k = 0; k < 8; k++) begin
            c_v = bc_v;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p_s[4*k+j] ^ c_v;
                c_v        = g_s[4*k+j] | (p_s[4*k+j] & c_v);
            end
            bc_v = (&p_s[4*k +: 4]) ? bc_v : c_v;
        end
        cout = bc_v;
    end

endmodule

// File: rtl/wide_add_seq.sv
// WORDS x 32-bit add/subtract sequenced through one shared 32-bit slice, LSW first,
// with valid/ready handshakes on operand and result sides.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int IW = idx_w(WORDS);
    localparam int W  = WORD_W * WORDS;

    state_t          state_r;
    state_t          state_nx_s;
    logic [W-1:0]    opa_r;
    logic [W-1:0]    opb_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic [IW-1:0]   idx_r;
    logic            cout_r;
    logic            ovf_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    logic [WORD_W-1:0] word_a_s;
    logic [WORD_W-1:0] word_b_s;
    logic [WORD_W-1:0] add_sum_s;
    logic              add_cout_s;
    logic              last_s;

    assign word_a_s = opa_r[WORD_W*int'(idx_r) +: WORD_W];
    assign word_b_s = opb_r[WORD_W*int'(idx_r) +: WORD_W];
    assign last_s   = (idx_r == IW'(WORDS - 1));

    carry_skip_32bit u_slice (
        .a    (word_a_s),
        .b    (word_b_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nx_s = RUN;
                else          state_nx_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nx_s = DONE;
                else        state_nx_s = RUN;
            end
            DONE: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and handshake/status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    // Operand capture, per-word writeback and final carry/overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r   <= '0;
            opb_r   <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        opa_r   <= a;
                        opb_r   <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[WORD_W*int'(idx_r) +: WORD_W] <= add_sum_s;
                    carry_r <= add_cout_s;
                    if (last_s) begin
                        cout_r <= add_cout_s;
                        // Operands share a sign but the result does not.
                        ovf_r  <= (opa_r[W-1] == opb_r[W-1]) &&
                                  (add_sum_s[WORD_W-1] != opa_r[W-1]);
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq (WORDS=4): expected results queued at accept, compared at out_valid.
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xcin, input logic xsub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   r;
        bb     = xsub ? ~xb : xb;
        r      = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, (xsub ? 1'b1 : xcin)};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (xa[W-1] == bb[W-1]) && (r[W-1] != xa[W-1]);
        return e;
    endfunction

    // Present one request, wait for the accept edge, record the expected result.
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xcin, input logic xsub);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check_val("in_ready_wait", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
        a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1;
        sb.push_back(model(xa, xb, xcin, xsub));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (latency checked), compare, optionally stall then consume.
    task automatic get_result(input int bp, input bit consume);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", W'(lat), W'(WORDS));
        e = sb.pop_front();
        check_val("sum", sum, e.sum);
        check_val("cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, e.cout});
        check_val("ovf", {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, e.ovf});
        for (int i = 0; i < bp; i++) begin
            in_valid = ~in_valid;
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check_val("bp_sum", sum, e.sum);
            check_val("bp_cout_ovf", {{(W-2){1'b0}}, cout, ovf}, {{(W-2){1'b0}}, e.cout, e.ovf});
            check_val("bp_flags", {{(W-3){1'b0}}, out_valid, in_ready, busy}, {{(W-3){1'b0}}, 3'b101});
        end
        in_valid = 1'b0;
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_val("post_consume", {{(W-3){1'b0}}, out_valid, in_ready, busy}, {{(W-3){1'b0}}, 3'b010});
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic reset_pulse();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("rst_sum", sum, '0);
        check_val("rst_flags", {{(W-4){1'b0}}, out_valid, busy, cout, ovf}, '0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", {{(W-2){1'b0}}, in_ready, out_valid}, {{(W-2){1'b0}}, 2'b10});
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] maxpos;
        ones   = '1;
        maxpos = {1'b0, {(W-1){1'b1}}};

        #3;
        check_val("init_sum", sum, '0);
        check_val("init_flags", {{(W-4){1'b0}}, out_valid, busy, cout, ovf}, '0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("init_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});

        send(ones, W'(1), 1'b0, 1'b0);          get_result(0, 1'b1);
        send('0, W'(1), 1'b1, 1'b1);            get_result(0, 1'b1);
        send(W'(5), W'(3), 1'b0, 1'b1);         get_result(0, 1'b1);
        send(maxpos, W'(1), 1'b0, 1'b0);        get_result(5, 1'b1);

        // Reset while a result is held in DONE.
        send(maxpos, W'(1), 1'b0, 1'b0);        get_result(1, 1'b0);
        reset_pulse();

        // Abort after two RUN cycles.
        send(W'(12345), W'(678), 1'b1, 1'b0);
        @(posedge clk); #1;
        check_val("abort_busy", {{(W-2){1'b0}}, busy, out_valid}, {{(W-2){1'b0}}, 2'b10});
        sb.delete();
        reset_pulse();
        send(W'(3), W'(4), 1'b0, 1'b0);         get_result(0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom), 1'($urandom));
            get_result(int'($urandom_range(0, 2)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
